lms_equalizer: RTL and testbench
================================

# lms_equalizer

Adaptive LMS FIR equalizer that undoes the inter-symbol interference introduced by the channel FIR model. It consumes the channel filter's Q(DATA_F) output stream and produces equalized samples, PAM2 slicer decisions and the error signal. Coefficients adapt from a training sequence first, then in decision-directed mode. It sits directly downstream of the channel filter in the link simulation/FPGA chain.

## Interface
- H, 7, number of taps
- W, 16, data width of din/dout/err
- DATA_F, 7, fractional bits of din/dout/err
- CW, 16, coefficient width
- COEF_F, 14, coefficient fractional bits; CW ≥ COEF_F+2 is required
- CENTER, 3, tap initialised to 1.0 at reset
- MU_SHIFT, 8, LMS step size 2^-MU_SHIFT; 2*DATA_F+MU_SHIFT ≥ COEF_F is required
- TRAIN_LEN, 1024, number of adapted samples in TRAIN; must be ≥1
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  din/train_sym are accepted this cycle
- din  in  W  signed Q(DATA_F) received sample
- train_sym  in  1  training symbol for this sample: 1 → +1.0, 0 → -1.0; already aligned to the decision delay by the source
- start  in  1  pulse: enter TRAIN and clear the training counter
- freeze  in  1  inhibits coefficient update and counter advance
- coef_sel  in  clog2(H)  coefficient readback index
- out_valid  out  1  dout/dec/err valid
- dout  out  W  signed Q(DATA_F) equalized sample, saturated
- dec  out  1  slicer decision, 1 when y ≥ 0
- err  out  W  signed Q(DATA_F) error ref−y, saturated
- mode  out  2  0 IDLE, 1 TRAIN, 2 DD
- coef_out  out  CW  combinational c[coef_sel]; 0 if coef_sel ≥ H

## Operation
- Delay line x[0..H-1]: on an edge with in_valid=1, x[0]←din, x[k]←x[k-1], ref_d←train_sym, s1_valid←1; otherwise s1_valid←0.
- Stage 1 (cycle with s1_valid=1), combinational from pre-edge values: acc = Σ x[k]*c[k] (full precision + clog2(H) guard bits); y = sat_W(acc >>> COEF_F), truncating.
- Reference: TRAIN uses ref_d ? +ONE : −ONE; DD uses y ≥ 0 ? +ONE : −ONE; ONE = 1<<DATA_F.
- e = sat_W(ref − y). In IDLE, e is still computed using the DD reference.
- Registered at the same edge: dout←y, dec←~y[W-1], err←e, out_valid←1.
- Update when s1_valid=1, mode∈{TRAIN,DD} and freeze=0: c[k] ← sat_CW(c[k] + ((e*x[k]) >>> (2*DATA_F+MU_SHIFT−COEF_F))). Arithmetic shift, truncation toward −∞.
- State machine:
  - IDLE: no adaptation.
  - start=1 in any state → TRAIN, cnt←0. Coefficients are kept.
  - TRAIN: each update increments cnt. The update with cnt=TRAIN_LEN−1 moves to DD.
  - DD: adapts indefinitely until start or rst.
- start coincident with an update: the update uses the pre-edge mode, and start wins for the next state/cnt.
- freeze=1: outputs still produced; coefficients, cnt and mode are held, except that start still applies.

## Timing
- Reset values (asynchronous): x=0, c[CENTER]=1<<COEF_F, other c=0, s1_valid=0, out_valid=0, dout=0, dec=0, err=0, mode=IDLE, cnt=0.
- Latency: in_valid in cycle T → out_valid in cycle T+2.
- Throughput: 1 sample/clock. Back-to-back in_valid is fully supported because stage 1 reads the pre-edge delay line.
- A coefficient update at the edge ending cycle T+1 is seen by the sample evaluated in cycle T+2 (no update delay).
- out_valid is a one-cycle pulse per accepted sample; there is no backpressure.
- rst mid-operation: all state clears immediately; an in-flight sample is dropped.

## Test plan
- Reset:
  - Stimulus: assert rst, then release.
  - Required response: out_valid=0, dout=err=0, mode=0; coef_out=16384 for coef_sel=3, and 0 for coef_sel=0,1,2,4,5,6 and for 7.
- IDLE impulse:
  - Stimulus: continuous in_valid, din=100,0,0,0,0.
  - Required response: dout=0,0,0,100,0; first out_valid 2 cycles after the first in_valid; coefficients unchanged.
- Single LMS step:
  - Stimulus: start, then din=128 followed by zeros, train_sym=1.
  - Required response: first output y=0, err=128; next cycle coef_out[0]=64; mode=1.
- Training to DD:
  - Stimulus: TRAIN_LEN=16, identity channel, din=±128, train_sym = symbol delayed by 3.
  - Required response: err=0 throughout, coefficients unchanged, mode becomes 2 after the 16th update.
- Saturation/freeze:
  - Stimulus: din=32767 continuous with freeze=1.
  - Required response: dout=32767; err saturates to −32768 range correctly; coefficients and mode unchanged.
- Reset mid-training:
  - Stimulus: assert rst asynchronously while out_valid=1 in TRAIN.
  - Required response: outputs zero before the next edge; coefficients return to their init values; mode=0.

Source files
------------

// File: rtl/lms_equalizer_if.sv
// ============================================================================
// lms_equalizer_if : sample-stream, control and readback bundle (rev 1.0)
// ============================================================================
`default_nettype none

interface lms_equalizer_if #(
  parameter int W  = 16,
  parameter int CW = 16,
  parameter int H  = 7
);
  localparam int SEL_W = (H > 1) ? $clog2(H) : 1;

  logic                    in_valid;
  logic signed [W-1:0]     din;
  logic                    train_sym;
  logic                    start;
  logic                    freeze;
  logic [SEL_W-1:0]        coef_sel;

  logic                    out_valid;
  logic signed [W-1:0]     dout;
  logic                    dec;
  logic signed [W-1:0]     err;
  logic [1:0]              mode;
  logic signed [CW-1:0]    coef_out;

  modport master (
    output in_valid, din, train_sym, start, freeze, coef_sel,
    input  out_valid, dout, dec, err, mode, coef_out
  );

  modport slave (
    input  in_valid, din, train_sym, start, freeze, coef_sel,
    output out_valid, dout, dec, err, mode, coef_out
  );
endinterface

`default_nettype wire

// File: rtl/lms_equalizer.sv
// ============================================================================
// lms_equalizer : adaptive LMS FIR equalizer with PAM2 slicer (rev 1.0)
// ============================================================================
`default_nettype none

module lms_equalizer #(
  parameter int H         = 7,
  parameter int W         = 16,
  parameter int DATA_F    = 7,
  parameter int CW        = 16,
  parameter int COEF_F    = 14,
  parameter int CENTER    = 3,
  parameter int MU_SHIFT  = 8,
  parameter int TRAIN_LEN = 1024
) (
  input  logic            clk,
  input  logic            rst,
  lms_equalizer_if.slave  eq_if
);

  localparam int GW    = (H > 1) ? $clog2(H) : 0;
  localparam int PW    = W + CW;
  localparam int AW    = PW + GW;
  localparam int EW    = 2 * W;
  localparam int SW    = ((CW > EW) ? CW : EW) + 1;
  localparam int SH    = 2 * DATA_F + MU_SHIFT - COEF_F;
  localparam int CNT_W = $clog2(TRAIN_LEN) + 1;

  localparam logic signed [W-1:0]  ONE_W     = W'(1 << DATA_F);
  localparam logic signed [W-1:0]  NEG_ONE_W = -ONE_W;
  localparam logic signed [CW-1:0] C_ONE     = CW'(1 << COEF_F);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(TRAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    DD    = 2'd2
  } mode_e;

  logic signed [W-1:0]  x_q [H];
  logic signed [CW-1:0] c_q [H];
  logic signed [CW-1:0] c_d [H];
  logic                 ref_sym_q;
  logic                 s1_valid_q;
  logic                 out_valid_q;
  logic signed [W-1:0]  dout_q;
  logic                 dec_q;
  logic signed [W-1:0]  err_q;
  mode_e                mode_q;
  logic [CNT_W-1:0]     cnt_q;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_sh;
  logic signed [W-1:0]  y;
  logic signed [W-1:0]  ref_val;
  logic signed [W:0]    diff;
  logic signed [W-1:0]  e;
  logic signed [EW-1:0] prod;
  logic signed [EW-1:0] delta;
  logic signed [SW-1:0] csum;
  logic                 upd_en;

  function automatic logic signed [W-1:0] sat_acc(input logic signed [AW-1:0] v);
    if ((&v[AW-1:W-1]) || !(|v[AW-1:W-1])) return v[W-1:0];
    return v[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  function automatic logic signed [W-1:0] sat_err(input logic signed [W:0] v);
    if (v[W] == v[W-1]) return v[W-1:0];
    return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  function automatic logic signed [CW-1:0] sat_coef(input logic signed [SW-1:0] v);
    if ((&v[SW-1:CW-1]) || !(|v[SW-1:CW-1])) return v[CW-1:0];
    return v[SW-1] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
  endfunction

  // Stage 1 reads the pre-edge delay line, so back-to-back samples never collide.
  always_comb begin
    acc = '0;
    for (int k = 0; k < H; k++) begin
      acc = acc + AW'(PW'(x_q[k]) * PW'(c_q[k]));
    end
    acc_sh = acc >>> COEF_F;
    y      = sat_acc(acc_sh);

    if (mode_q == TRAIN) ref_val = ref_sym_q ? ONE_W : NEG_ONE_W;
    else                 ref_val = y[W-1] ? NEG_ONE_W : ONE_W;

    diff   = (W+1)'(ref_val) - (W+1)'(y);
    e      = sat_err(diff);
    upd_en = s1_valid_q && (mode_q != IDLE) && !eq_if.freeze;

    prod  = '0;
    delta = '0;
    csum  = '0;
    for (int k = 0; k < H; k++) begin
      prod   = EW'(e) * EW'(x_q[k]);
      delta  = prod >>> SH;
      csum   = SW'(c_q[k]) + SW'(delta);
      c_d[k] = upd_en ? sat_coef(csum) : c_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < H; k++) begin
        x_q[k] <= '0;
        c_q[k] <= (k == CENTER) ? C_ONE : '0;
      end
      ref_sym_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      dec_q       <= 1'b0;
      err_q       <= '0;
      mode_q      <= IDLE;
      cnt_q       <= '0;
    end else begin
      if (eq_if.in_valid) begin
        x_q[0]    <= eq_if.din;
        for (int k = 1; k < H; k++) x_q[k] <= x_q[k-1];
        ref_sym_q <= eq_if.train_sym;
      end
      s1_valid_q  <= eq_if.in_valid;
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        dout_q <= y;
        dec_q  <= ~y[W-1];
        err_q  <= e;
      end
      for (int k = 0; k < H; k++) c_q[k] <= c_d[k];

      // start overrides the counter/mode advance of a coincident update.
      if (eq_if.start) begin
        mode_q <= TRAIN;
        cnt_q  <= '0;
      end else if (upd_en && (mode_q == TRAIN)) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) mode_q <= DD;
      end
    end
  end

  always_comb begin
    eq_if.coef_out = '0;
    if (32'(eq_if.coef_sel) < H) eq_if.coef_out = c_q[eq_if.coef_sel];
  end

  assign eq_if.out_valid = out_valid_q;
  assign eq_if.dout      = dout_q;
  assign eq_if.dec       = dec_q;
  assign eq_if.err       = err_q;
  assign eq_if.mode      = mode_q;

endmodule

`default_nettype wire

// File: tb/tb_lms_equalizer.sv
// ============================================================================
// tb_lms_equalizer : directed self-checking bench for lms_equalizer (rev 1.0)
// ============================================================================
`default_nettype none

module tb_lms_equalizer;

  localparam int H = 7, W = 16, DATA_F = 7, CW = 16, COEF_F = 14;
  localparam int CENTER = 3, MU_SHIFT = 8, TRAIN_LEN = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lms_equalizer_if #(.W(W), .CW(CW), .H(H)) bus ();

  lms_equalizer #(
    .H(H), .W(W), .DATA_F(DATA_F), .CW(CW), .COEF_F(COEF_F),
    .CENTER(CENTER), .MU_SHIFT(MU_SHIFT), .TRAIN_LEN(TRAIN_LEN)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .eq_if (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    bit rs; bit iv; int din; bit ts; bit st; bit fz; int sel;
    bit ev; int ed; int ee; bit edec; int em; int ec;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.train_sym = 1'b0;
    bus.start     = 1'b0;
    bus.freeze    = 1'b0;
    bus.coef_sel  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic chk_coef(input int sel, input int exp, input string nm);
    bus.coef_sel = 3'(sel);
    #1;
    chk($sformatf("%s coef[%0d]", nm, sel), bus.coef_out, exp);
  endtask

  function automatic int dval(input bit b);
    return b ? 128 : -128;
  endfunction

  initial begin
    logic [31:0] pat;
    int m;
    pat = 32'hB38D_6A5C;

    //           rs iv  din   ts st fz sel ev  ed   ee   dec em  ec
    tbl[0]  = '{1, 1, 100,   0, 0, 0, 0,  0, 0,   0,   0,  0, 0};
    tbl[1]  = '{0, 1, 0,     0, 0, 0, 1,  1, 0,   128, 1,  0, 0};
    tbl[2]  = '{0, 1, 0,     0, 0, 0, 2,  1, 0,   128, 1,  0, 0};
    tbl[3]  = '{0, 1, 0,     0, 0, 0, 3,  1, 0,   128, 1,  0, 16384};
    tbl[4]  = '{0, 1, 0,     0, 0, 0, 4,  1, 100, 28,  1,  0, 0};
    tbl[5]  = '{0, 0, 0,     0, 0, 0, 5,  1, 0,   128, 1,  0, 0};
    tbl[6]  = '{0, 0, 0,     0, 0, 0, 6,  0, 0,   0,   0,  0, 0};
    tbl[7]  = '{0, 0, 0,     0, 0, 0, 7,  0, 0,   0,   0,  0, 0};
    tbl[8]  = '{1, 0, 0,     0, 1, 0, 0,  0, 0,   0,   0,  1, 0};
    tbl[9]  = '{0, 1, 128,   1, 0, 0, 0,  0, 0,   0,   0,  1, 0};
    tbl[10] = '{0, 1, 0,     1, 0, 0, 0,  1, 0,   128, 1,  1, 64};
    tbl[11] = '{0, 0, 0,     0, 0, 0, 1,  1, 0,   128, 1,  1, 64};
    tbl[12] = '{0, 0, 0,     0, 0, 0, 0,  0, 0,   0,   0,  1, 64};
    tbl[13] = '{0, 0, 0,     0, 0, 0, 3,  0, 0,   0,   0,  1, 16384};

    rst = 1'b1;
    do_reset();
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst dout", bus.dout, 0);
    chk("rst err", bus.err, 0);
    chk("rst dec", bus.dec, 0);
    chk("rst mode", bus.mode, 0);
    for (int s = 0; s < 8; s++) chk_coef(s, (s == CENTER) ? 16384 : 0, "rst");

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rs) do_reset();
      bus.in_valid  = tbl[i].iv;
      bus.din       = 16'(tbl[i].din);
      bus.train_sym = tbl[i].ts;
      bus.start     = tbl[i].st;
      bus.freeze    = tbl[i].fz;
      bus.coef_sel  = 3'(tbl[i].sel);
      tick();
      chk($sformatf("v%0d out_valid", i), bus.out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d dout", i), bus.dout, tbl[i].ed);
        chk($sformatf("v%0d err", i), bus.err, tbl[i].ee);
        chk($sformatf("v%0d dec", i), bus.dec, tbl[i].edec);
      end
      chk($sformatf("v%0d mode", i), bus.mode, tbl[i].em);
      chk($sformatf("v%0d coef_out", i), bus.coef_out, tbl[i].ec);
    end

    // Training on an identity channel: prime the delay line in IDLE first.
    do_reset();
    for (int n = 0; n < 3; n++) begin
      bus.in_valid = 1'b1;
      bus.din      = 16'(dval(pat[n]));
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("train start mode", bus.mode, 1);
    for (int j = 3; j <= 23; j++) begin
      bus.in_valid  = (j <= 22);
      bus.din       = 16'(dval(pat[j]));
      bus.train_sym = pat[j-3];
      tick();
      if (j >= 4) begin
        m = j - 1;
        chk($sformatf("train s%0d out_valid", m), bus.out_valid, 1);
        chk($sformatf("train s%0d dout", m), bus.dout, dval(pat[m-3]));
        chk($sformatf("train s%0d err", m), bus.err, 0);
        chk($sformatf("train s%0d dec", m), bus.dec, pat[m-3]);
        chk($sformatf("train s%0d mode", m), bus.mode, (m - 2 < TRAIN_LEN) ? 1 : 2);
      end
    end
    for (int s = 0; s < H; s++) chk_coef(s, (s == CENTER) ? 16384 : 0, "train");

    // Full-scale input with freeze held: outputs saturate, state does not move.
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.freeze = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      bus.in_valid  = (j < 8);
      bus.din       = 16'sd32767;
      bus.train_sym = 1'b0;
      tick();
      if (j >= 1) begin
        m = j - 1;
        chk($sformatf("sat s%0d dout", m), bus.dout, (m >= 3) ? 32767 : 0);
        chk($sformatf("sat s%0d err", m), bus.err, (m >= 3) ? -32768 : -128);
        chk($sformatf("sat s%0d mode", m), bus.mode, 1);
      end
    end
    chk_coef(0, 0, "freeze");
    chk_coef(3, 16384, "freeze");
    chk_coef(2, 0, "freeze");
    bus.freeze = 1'b0;

    // Asynchronous reset while a training output is being presented.
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.din       = 16'sd128;
    bus.train_sym = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.din      = '0;
    tick();
    chk("midrst pre out_valid", bus.out_valid, 1);
    chk("midrst pre err", bus.err, 128);
    chk_coef(0, 64, "midrst pre");
    rst = 1'b1;
    #1;
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst dout", bus.dout, 0);
    chk("midrst err", bus.err, 0);
    chk("midrst dec", bus.dec, 0);
    chk("midrst mode", bus.mode, 0);
    chk("midrst coef[0]", bus.coef_out, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk_coef(3, 16384, "midrst");
    tick();
    chk("midrst post out_valid", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
